tl_cntr_param: RTL and testbench
================================

TL_CNTR_PARAM -- requirements
Module: tl_cntr_param

Interface
REQ-001 SHALL have parameter TW, default 8: width of the internal dwell counter.
REQ-002 SHALL have parameter MIN_GRN, default 4: minimum green dwell in cycles; legal range 1..MAX_GRN.
REQ-003 SHALL have parameter MAX_GRN, default 16: maximum green dwell in cycles; legal range MIN_GRN..2^TW-1.
REQ-004 SHALL have parameter YEL_CYC, default 3: yellow dwell in cycles; legal range 1..2^TW-1.
REQ-005 SHALL have parameter SKIP_LEFT, default 1: 1 = skip a left phase that has no demand; 0 = always serve every left phase.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port Ta, input, 1 bit: traffic present on street A, through movement.
REQ-009 SHALL have port Tal, input, 1 bit: traffic present on street A, left turn.
REQ-010 SHALL have port Tb, input, 1 bit: traffic present on street B, through movement.
REQ-011 SHALL have port Tbl, input, 1 bit: traffic present on street B, left turn.
REQ-012 SHALL have output ports La, Lal, Lb, Lbl, 2 bits each: light colour per movement; 00 = green, 01 = yellow, 10 = red; 11 is never driven.
REQ-013 SHALL have port state, output, 3 bits: current state encoding, for debug.

Function
REQ-014 SHALL implement an 8-state Moore FSM with these encodings:
- S0 = 000, A green
- S1 = 001, A yellow
- S2 = 010, A-left green
- S3 = 011, A-left yellow
- S4 = 100, B green
- S5 = 101, B yellow
- S6 = 110, B-left green
- S7 = 111, B-left yellow
REQ-015 SHALL decode the light outputs from the state register only; each output is its movement's green/yellow colour in that movement's two states, and 10 (red) otherwise.
REQ-016 SHALL clear the dwell counter cnt to 0 on every state change, and otherwise increment it by 1 each cycle, saturating at 2^TW-1.
REQ-017 SHALL, in each green state (S0, S2, S4, S6) with its own sensor Tx (Ta, Tal, Tb, Tbl respectively), exit at a clock edge when (Tx==0 and cnt>=MIN_GRN-1) or cnt>=MAX_GRN-1.
- Green dwell is therefore MIN_GRN..MAX_GRN cycles.
- MAX_GRN forces exit even with continuous demand (no starvation).
REQ-018 SHALL, in each yellow state, exit at the edge where cnt==YEL_CYC-1; yellow dwell is exactly YEL_CYC cycles.
REQ-019 SHALL use these transitions: S0->S1, S2->S3, S4->S5, S6->S7, S3->S4, S7->S0.
REQ-020 SHALL, on S1 exit, go to S2, except go to S4 when SKIP_LEFT==1 and Tal==0 at that edge.
REQ-021 SHALL, on S5 exit, go to S6, except go to S0 when SKIP_LEFT==1 and Tbl==0 at that edge.
REQ-022 SHALL sample sensors only at clock edges; a sensor change between edges has no effect.
REQ-023 SHALL ignore a sensor's demand rising during its movement's yellow state; the yellow state still completes YEL_CYC cycles.
REQ-024 SHALL never drive green or yellow on conflicting movements: at most one of La, Lal, Lb, Lbl is non-red in any cycle.

Reset
REQ-025 SHALL, while reset==1, immediately force state=S0 and cnt=0, independent of clk.
REQ-026 SHALL drive these values during reset: La=00, Lal=10, Lb=10, Lbl=10.
REQ-027 SHALL, on reset release, start S0 with cnt=0 at the first rising clk edge; reset asserted mid-phase abandons that phase with no yellow.

Verification (defaults unless stated)
REQ-028 SHALL be covered by: reset pulsed while in S5 -> state=000, La=00, Lb=10 within the same cycle, without waiting for a clock edge.
REQ-029 SHALL be covered by: Ta=1 held, all other sensors 0 -> S0 for 16 cycles, S1 for 3 cycles, then S4 (left skipped).
REQ-030 SHALL be covered by: Ta=0 from reset -> S0 held exactly 4 cycles, then S1.
REQ-031 SHALL be covered by: Tal=1 at the S1 exit edge -> S2; Tal dropped at S2 cnt=1 -> S2 held 4 cycles total, then S3.
REQ-032 SHALL be covered by: SKIP_LEFT=0, all sensors 0 -> sequence S0..S7 with dwells 4,3,4,3,4,3,4,3, and a 28-cycle period repeating.
REQ-033 SHALL be covered by: random sensor stimulus over at least 10000 cycles with an assertion that REQ-024 holds and no output ever equals 11.

Source files
------------

// File: rtl/tl_cntr_param.sv
// Four-movement traffic-light controller: A, A-left, B, B-left served in turn,
// with sensor-driven green dwell bounded by MIN_GRN/MAX_GRN and fixed yellow.
module tl_cntr_param #(
  parameter int unsigned TW        = 8,
  parameter int unsigned MIN_GRN   = 4,
  parameter int unsigned MAX_GRN   = 16,
  parameter int unsigned YEL_CYC   = 3,
  parameter int unsigned SKIP_LEFT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Ta,
  input  logic       Tal,
  input  logic       Tb,
  input  logic       Tbl,
  output logic [1:0] La,
  output logic [1:0] Lal,
  output logic [1:0] Lb,
  output logic [1:0] Lbl,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S0 = 3'b000,  // A green
    S1 = 3'b001,  // A yellow
    S2 = 3'b010,  // A-left green
    S3 = 3'b011,  // A-left yellow
    S4 = 3'b100,  // B green
    S5 = 3'b101,  // B yellow
    S6 = 3'b110,  // B-left green
    S7 = 3'b111   // B-left yellow
  } state_e;

  localparam logic [TW-1:0] CNT_MAX = '1;
  localparam logic [TW-1:0] MIN_LIM = TW'(MIN_GRN - 1);
  localparam logic [TW-1:0] MAX_LIM = TW'(MAX_GRN - 1);
  localparam logic [TW-1:0] YEL_LIM = TW'(YEL_CYC - 1);
  localparam logic          SKIP_EN = (SKIP_LEFT == 1);

  localparam logic [1:0] GRN = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] RED = 2'b10;

  state_e        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          dmd;
  logic          grn_exit;
  logic          yel_exit;

  // State and dwell counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Demand of the movement owning the current state (state bits [2:1])
  always_comb begin
    dmd = 1'b0;
    case (state_q[2:1])
      2'b00: dmd = Ta;
      2'b01: dmd = Tal;
      2'b10: dmd = Tb;
      2'b11: dmd = Tbl;
      default: dmd = 1'b0;
    endcase
  end

  assign grn_exit = (!dmd && (cnt_q >= MIN_LIM)) || (cnt_q >= MAX_LIM);
  assign yel_exit = (cnt_q == YEL_LIM);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S0: if (grn_exit) state_d = S1;
      S1: if (yel_exit) state_d = (SKIP_EN && !Tal) ? S4 : S2;
      S2: if (grn_exit) state_d = S3;
      S3: if (yel_exit) state_d = S4;
      S4: if (grn_exit) state_d = S5;
      S5: if (yel_exit) state_d = (SKIP_EN && !Tbl) ? S0 : S6;
      S6: if (grn_exit) state_d = S7;
      S7: if (yel_exit) state_d = S0;
      default: state_d = S0;
    endcase
  end

  // Dwell counter: restart on state change, otherwise saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  // Light decode straight from the state register
  always_comb begin
    La  = RED;
    Lal = RED;
    Lb  = RED;
    Lbl = RED;
    case (state_q)
      S0: La  = GRN;
      S1: La  = YEL;
      S2: Lal = GRN;
      S3: Lal = YEL;
      S4: Lb  = GRN;
      S5: Lb  = YEL;
      S6: Lbl = GRN;
      S7: Lbl = YEL;
      default: La = RED;
    endcase
  end

  assign state = state_q;

endmodule

// File: tb/tb_tl_cntr_param.sv
// Directed checks of tl_cntr_param dwell/sequencing plus a randomised
// exclusivity and light-decode sweep on default and no-skip instances.
module tb_tl_cntr_param;

  logic       clk;
  logic       reset;
  logic       Ta, Tal, Tb, Tbl;
  logic [1:0] La, Lal, Lb, Lbl;
  logic [2:0] state;
  logic       n_ta, n_tal, n_tb, n_tbl;
  logic [1:0] n_la, n_lal, n_lb, n_lbl;
  logic [2:0] n_state;

  int n_total;
  int n_pass;

  tl_cntr_param dut (
    .clk(clk), .reset(reset),
    .Ta(Ta), .Tal(Tal), .Tb(Tb), .Tbl(Tbl),
    .La(La), .Lal(Lal), .Lb(Lb), .Lbl(Lbl),
    .state(state)
  );

  tl_cntr_param #(.SKIP_LEFT(0)) dut_ns (
    .clk(clk), .reset(reset),
    .Ta(n_ta), .Tal(n_tal), .Tb(n_tb), .Tbl(n_tbl),
    .La(n_la), .Lal(n_lal), .Lb(n_lb), .Lbl(n_lbl),
    .state(n_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Count consecutive samples (one per cycle) in state s on the default DUT
  task automatic dwell(input logic [2:0] s, output int n);
    n = 0;
    while (state == s && n < 300) begin
      n++;
      step();
    end
  endtask

  task automatic dwell_ns(input logic [2:0] s, output int n);
    n = 0;
    while (n_state == s && n < 300) begin
      n++;
      step();
    end
  endtask

  // Hold reset over an edge, release at a falling edge
  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [1:0] exp_light(input logic [2:0] s, input logic [1:0] mv);
    if (s[2:1] != mv) return 2'b10;
    return s[0] ? 2'b01 : 2'b00;
  endfunction

  initial begin
    int n;
    int tot;
    int viol;
    int run;
    int nonred;
    logic [2:0] prev;
    logic [2:0] exp_seq [8];
    int exp_dw [8];

    n_total = 0;
    n_pass  = 0;
    reset = 1'b1;
    {Ta, Tal, Tb, Tbl} = 4'b0;
    {n_ta, n_tal, n_tb, n_tbl} = 4'b0;

    // Reset values
    #12;
    check("rst_state", 16'(state), 16'd0);
    check("rst_La",  16'(La),  16'd0);
    check("rst_Lal", 16'(Lal), 16'd2);
    check("rst_Lb",  16'(Lb),  16'd2);
    check("rst_Lbl", 16'(Lbl), 16'd2);

    // No demand: minimum green, yellow, left skipped; Ta rising in yellow ignored
    @(negedge clk);
    reset = 1'b0;
    dwell(3'd0, n);  check("a_s0_dwell", 16'(n), 16'd4);
    check("a_s1_entry", 16'(state), 16'd1);
    Ta = 1'b1;
    dwell(3'd1, n);  check("a_s1_dwell", 16'(n), 16'd3);
    Ta = 1'b0;
    check("a_skip_to_s4", 16'(state), 16'd4);
    dwell(3'd4, n);  check("a_s4_dwell", 16'(n), 16'd4);
    check("a_s5_entry", 16'(state), 16'd5);

    // Asynchronous reset mid-yellow
    step();
    #2;
    reset = 1'b1;
    #1;
    check("ar_state", 16'(state), 16'd0);
    check("ar_La", 16'(La), 16'd0);
    check("ar_Lb", 16'(Lb), 16'd2);
    @(negedge clk);
    reset = 1'b0;

    // Continuous Ta demand: forced out at MAX_GRN
    Ta = 1'b1;
    do_reset();
    dwell(3'd0, n);  check("b_s0_max", 16'(n), 16'd16);
    dwell(3'd1, n);  check("b_s1_dwell", 16'(n), 16'd3);
    check("b_skip_to_s4", 16'(state), 16'd4);
    Ta = 1'b0;

    // Left demand at S1 exit, dropped at S2 cnt=1
    Tal = 1'b1;
    do_reset();
    dwell(3'd0, n);  check("c_s0_dwell", 16'(n), 16'd4);
    dwell(3'd1, n);  check("c_s1_dwell", 16'(n), 16'd3);
    check("c_s2_entry", 16'(state), 16'd2);
    step();
    Tal = 1'b0;
    check("c_s2_cnt1", 16'(state), 16'd2);
    dwell(3'd2, n);  check("c_s2_dwell", 16'(n + 1), 16'd4);
    check("c_s3_entry", 16'(state), 16'd3);
    check("c_Lal_yel", 16'(Lal), 16'd1);
    dwell(3'd3, n);  check("c_s3_dwell", 16'(n), 16'd3);
    check("c_s4_entry", 16'(state), 16'd4);

    // Tb with Tbl demand into B-left; B held 6 cycles then released
    Tb = 1'b1;
    for (int k = 0; k < 5; k++) step();
    Tb = 1'b0;
    Tbl = 1'b1;
    dwell(3'd4, n);  check("d_s4_dwell", 16'(n + 5), 16'd6);
    dwell(3'd5, n);  check("d_s5_dwell", 16'(n), 16'd3);
    check("d_s6_entry", 16'(state), 16'd6);
    check("d_Lbl_grn", 16'(Lbl), 16'd0);
    Tbl = 1'b0;
    dwell(3'd6, n);  check("d_s6_dwell", 16'(n), 16'd4);
    dwell(3'd7, n);  check("d_s7_dwell", 16'(n), 16'd3);
    check("d_wrap_s0", 16'(state), 16'd0);

    // SKIP_LEFT=0, no demand: full 8-state cycle, 28-cycle period, twice
    do_reset();
    for (int i = 0; i < 8; i++) begin
      exp_seq[i] = 3'(i);
      exp_dw[i]  = (i % 2 == 0) ? 4 : 3;
    end
    for (int p = 0; p < 2; p++) begin
      tot = 0;
      for (int i = 0; i < 8; i++) begin
        check($sformatf("ns_state_p%0d_%0d", p, i), 16'(n_state), 16'(exp_seq[i]));
        dwell_ns(exp_seq[i], n);
        check($sformatf("ns_dwell_p%0d_%0d", p, i), 16'(n), 16'(exp_dw[i]));
        tot += n;
      end
      check($sformatf("ns_period_%0d", p), 16'(tot), 16'd28);
    end

    // Random sensors: exclusivity, no 11, decode vs state, dwell bounds
    do_reset();
    viol = 0;
    prev = state;
    run  = 0;
    for (int i = 0; i < 10000; i++) begin
      if (i > 0) @(negedge clk);
      nonred = 0;
      if (La  != 2'b10) nonred++;
      if (Lal != 2'b10) nonred++;
      if (Lb  != 2'b10) nonred++;
      if (Lbl != 2'b10) nonred++;
      if (nonred > 1) viol++;
      nonred = 0;
      if (n_la  != 2'b10) nonred++;
      if (n_lal != 2'b10) nonred++;
      if (n_lb  != 2'b10) nonred++;
      if (n_lbl != 2'b10) nonred++;
      if (nonred > 1) viol++;
      if (La == 2'b11 || Lal == 2'b11 || Lb == 2'b11 || Lbl == 2'b11) viol++;
      if (n_la == 2'b11 || n_lal == 2'b11 || n_lb == 2'b11 || n_lbl == 2'b11) viol++;
      if (La != exp_light(state, 2'd0) || Lal != exp_light(state, 2'd1) ||
          Lb != exp_light(state, 2'd2) || Lbl != exp_light(state, 2'd3)) viol++;
      if (n_la != exp_light(n_state, 2'd0) || n_lal != exp_light(n_state, 2'd1) ||
          n_lb != exp_light(n_state, 2'd2) || n_lbl != exp_light(n_state, 2'd3)) viol++;
      if (state != prev) begin
        if (prev[0] && run != 3) viol++;
        if (!prev[0] && (run < 4 || run > 16)) viol++;
        if (!prev[0] && state != prev + 3'd1) viol++;
        if (prev == 3'd1 && state != 3'd2 && state != 3'd4) viol++;
        if (prev == 3'd3 && state != 3'd4) viol++;
        if (prev == 3'd5 && state != 3'd6 && state != 3'd0) viol++;
        if (prev == 3'd7 && state != 3'd0) viol++;
        prev = state;
        run  = 1;
      end else begin
        run++;
      end
      {Ta, Tal, Tb, Tbl} = 4'($urandom_range(15));
      {n_ta, n_tal, n_tb, n_tbl} = 4'($urandom_range(15));
    end
    check("rand_violations", 16'(viol), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
